aoi_exp_operand_stage: RTL and testbench



---
 rtl/aoi_stage_pkg.sv | 15 +
 rtl/aoi_settle_timer.sv | 40 ++++
 rtl/aoi_exp_operand_stage.sv | 145 ++++++++++++++
 tb/tb_aoi_exp_operand_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_stage_pkg.sv
// rtl/aoi_stage_pkg.sv - shared types and constants for the AOI expander operand stage
package aoi_stage_pkg;

    localparam int VEC_W  = 10;
    localparam int ONES_W = 11;
    localparam logic [VEC_W-1:0] SWEEP_LAST = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2,
        SWEEP  = 2'd3
    } stage_state_e;

endpackage

// File: rtl/aoi_settle_timer.sv
// rtl/aoi_settle_timer.sv - loadable down-counter that flags expiry at zero
module aoi_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("aoi_settle_timer: SETTLE_CYCLES must be at least 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/aoi_exp_operand_stage.sv
// rtl/aoi_exp_operand_stage.sv - drives operands A..J to the AOI expander and returns sampled Y
// Optional exhaustive Y=1 sweep is compiled in with AOI_EXP_SWEEP_EN.
module aoi_exp_operand_stage
    import aoi_stage_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [VEC_W-1:0] in_vec_i,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    output logic             e_o,
    output logic             f_o,
    output logic             g_o,
    output logic             h_o,
    output logic             i_o,
    output logic             j_o,
    input  logic             y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_y_o,
    output logic [VEC_W-1:0] out_vec_o
`ifdef AOI_EXP_SWEEP_EN
    ,
    input  logic              sweep_start_i,
    output logic              sweep_busy_o,
    output logic [ONES_W-1:0] sweep_ones_o
`endif
);

    stage_state_e     state_q, state_d;
    logic [VEC_W-1:0] ops_q, ops_d;
    logic             out_y_q, out_y_d;
    logic [VEC_W-1:0] out_vec_q, out_vec_d;
    logic             timer_load, timer_en, timer_expire;
`ifdef AOI_EXP_SWEEP_EN
    logic [ONES_W-1:0] ones_q, ones_d;
`endif

    // One timer serves both the single-vector settle and every sweep step.
    aoi_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    assign timer_en = (state_q == SETTLE) || (state_q == SWEEP);

    always_comb begin
        state_d    = state_q;
        ops_d      = ops_q;
        out_y_d    = out_y_q;
        out_vec_d  = out_vec_q;
        timer_load = 1'b0;
`ifdef AOI_EXP_SWEEP_EN
        ones_d     = ones_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d    = SETTLE;
                    ops_d      = in_vec_i;
                    timer_load = 1'b1;
`ifdef AOI_EXP_SWEEP_EN
                end else if (sweep_start_i) begin
                    state_d    = SWEEP;
                    ops_d      = '0;
                    ones_d     = '0;
                    timer_load = 1'b1;
`endif
                end
            end
            SETTLE: begin
                if (timer_expire) begin
                    out_y_d   = y_i;
                    out_vec_d = ops_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
`ifdef AOI_EXP_SWEEP_EN
            SWEEP: begin
                if (timer_expire) begin
                    ones_d = ones_q + {{(ONES_W-1){1'b0}}, y_i};
                    if (ops_q == SWEEP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ops_d      = ops_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            out_y_q   <= 1'b0;
            out_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            out_y_q   <= out_y_d;
            out_vec_q <= out_vec_d;
        end
    end

`ifdef AOI_EXP_SWEEP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign sweep_busy_o = (state_q == SWEEP);
    assign sweep_ones_o = ones_q;
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_y_o     = out_y_q;
    assign out_vec_o   = out_vec_q;

    assign {a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o, i_o, j_o} = ops_q;

endmodule

// File: tb/tb_aoi_exp_operand_stage.sv
// tb/tb_aoi_exp_operand_stage.sv - directed self-checking bench for aoi_exp_operand_stage
module tb_aoi_exp_operand_stage;

    localparam int SC = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_vec;
    logic       a, b, c, d, e, f, g, h, i, j;
    logic       y;
    logic       out_valid;
    logic       out_ready;
    logic       out_y;
    logic [9:0] out_vec;
`ifdef AOI_EXP_SWEEP_EN
    logic        sweep_start;
    logic        sweep_busy;
    logic [10:0] sweep_ones;
`endif

    logic       y_mode;
    logic       y_const;
    logic [9:0] ops;

    int n_vec  = 0;
    int n_miss = 0;

    assign ops = {a, b, c, d, e, f, g, h, i, j};
    // Expander stub: X=0, XBAR=1, so Y depends on the four AND pairs only.
    assign y = y_mode ? ~((a & b) | (c & d) | (e & f) | (g & h)) : y_const;

    aoi_exp_operand_stage #(
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_vec_i    (in_vec),
        .a_o         (a),
        .b_o         (b),
        .c_o         (c),
        .d_o         (d),
        .e_o         (e),
        .f_o         (f),
        .g_o         (g),
        .h_o         (h),
        .i_o         (i),
        .j_o         (j),
        .y_i         (y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_y_o     (out_y),
        .out_vec_o   (out_vec)
`ifdef AOI_EXP_SWEEP_EN
        ,
        .sweep_start_i (sweep_start),
        .sweep_busy_o  (sweep_busy),
        .sweep_ones_o  (sweep_ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        y_mode    = 1'b0;
        y_const   = 1'b0;
`ifdef AOI_EXP_SWEEP_EN
        sweep_start = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ops",       ops,       0);
        check("rst_out_y",     out_y,     0);
        check("rst_out_vec",   out_vec,   0);
`ifdef AOI_EXP_SWEEP_EN
        check("rst_sweep_busy", sweep_busy, 0);
        check("rst_sweep_ones", sweep_ones, 0);
`endif

        // Vector 0x2A5 with Y=1, consumer stalls five cycles.
        in_valid = 1'b1;
        in_vec   = 10'h2A5;
        y_const  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("v1_ops",        ops,       10'h2A5);
        check("v1_in_ready",   in_ready,  0);
        check("v1_valid_t0",   out_valid, 0);
        tick();
        check("v1_valid_t1",   out_valid, 0);
        tick();
        check("v1_valid_t2",   out_valid, 1);
        check("v1_out_y",      out_y,     1);
        check("v1_out_vec",    out_vec,   10'h2A5);

        y_const  = 1'b0;
        in_valid = 1'b1;
        in_vec   = 10'h155;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid",    out_valid, 1);
            check("stall_out_y",    out_y,     1);
            check("stall_out_vec",  out_vec,   10'h2A5);
            check("stall_in_ready", in_ready,  0);
            check("stall_ops",      ops,       10'h2A5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hs_valid_low", out_valid, 0);
        check("hs_in_ready",  in_ready,  1);
        check("idle_ops_hold", ops,      10'h2A5);

        // Vector 0x155 with Y=0, consumer always ready.
        in_valid = 1'b1;
        in_vec   = 10'h155;
        tick();
        in_valid = 1'b0;
        check("v2_ops", ops, 10'h155);
        tick();
        tick();
        check("v2_valid",   out_valid, 1);
        check("v2_out_y",   out_y,     0);
        check("v2_out_vec", out_vec,   10'h155);
        tick();
        check("v2_valid_one_cycle", out_valid, 0);
        check("v2_in_ready",        in_ready,  1);
        tick();
        check("v2_ops_hold", ops, 10'h155);

        // Reset one cycle after accepting 0x3C0 aborts the operation.
        y_const  = 1'b1;
        in_valid = 1'b1;
        in_vec   = 10'h3C0;
        tick();
        in_valid = 1'b0;
        check("v3_ops", ops, 10'h3C0);
        rst_n = 1'b0;
        #1;
        check("abort_ops",       ops,       0);
        check("abort_in_ready",  in_ready,  1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_vec",   out_vec,   0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        check("abort_ops_idle", ops,  0);

`ifdef AOI_EXP_SWEEP_EN
        begin
            int busy_cycles;
            int valid_seen;
            int guard;
            y_mode      = 1'b1;
            sweep_start = 1'b1;
            tick();
            sweep_start = 1'b0;
            busy_cycles = 0;
            valid_seen  = 0;
            guard       = 0;
            while (sweep_busy && guard < 1024*SC + 100) begin
                busy_cycles++;
                if (out_valid || in_ready) valid_seen++;
                tick();
                guard++;
            end
            check("sweep_busy_cycles", busy_cycles, 1024*SC);
            check("sweep_no_handshake", valid_seen, 0);
            check("sweep_ones",        sweep_ones,  324);
            check("sweep_ops_last",    ops,         10'h3FF);
            check("sweep_in_ready",    in_ready,    1);
            tick();
            check("sweep_ones_hold",   sweep_ones,  324);

            y_mode      = 1'b0;
            y_const     = 1'b1;
            in_valid    = 1'b1;
            sweep_start = 1'b1;
            in_vec      = 10'h001;
            tick();
            in_valid    = 1'b0;
            sweep_start = 1'b0;
            check("arb_sweep_busy", sweep_busy, 0);
            check("arb_ops",        ops,        10'h001);
            check("arb_in_ready",   in_ready,   0);
            tick();
            tick();
            check("arb_valid",      out_valid,  1);
            check("arb_out_vec",    out_vec,    10'h001);
            check("arb_ones_kept",  sweep_ones, 324);
            tick();
            check("arb_busy_after", sweep_busy, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
